// File: rtl/alu_div_sched.sv
// Sequential restoring divider shared by two requesters through a round-robin arbiter.
// Operands are captured at grant, and the result is held until the consumer accepts it.
module alu_div_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_dividend,
    input  logic [2*WIDTH-1:0] req_divisor,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_quotient,
    output logic [WIDTH-1:0]   rsp_remainder,
    output logic               rsp_div_zero,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic             dz_q, dz_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             gnt_any, gnt_idx;
    logic [WIDTH-1:0] sel_dvd, sel_dvs;
    logic [WIDTH:0]   shifted, diff;
    logic             ge;

    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = 1'b0;
        req_ready = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   gnt_idx = 1'b0;
                2'b10:   gnt_idx = 1'b1;
                2'b11:   gnt_idx = ~last_q;
                default: gnt_idx = 1'b0;
            endcase
            gnt_any   = |req_valid;
            req_ready = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign sel_dvd = gnt_idx ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
    assign sel_dvs = gnt_idx ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];

    // rem < divisor keeps shifted < 2*divisor, so the top bit of diff is a clean borrow flag.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[WIDTH];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        dz_d    = dz_q;
        vld_d   = vld_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    id_d   = gnt_idx;
                    last_d = gnt_idx;
                    dvd_d  = sel_dvd;
                    dvs_d  = sel_dvs;
                    if (sel_dvs == '0) begin
                        quo_d   = '1;
                        rem_d   = sel_dvd;
                        dz_d    = 1'b1;
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        rem_d   = '0;
                        dz_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                quo_d = {quo_q[WIDTH-2:0], ge};
                rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                if (cnt_q == CW'(WIDTH - 1)) begin
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            dz_q    <= 1'b0;
            vld_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dz_q    <= dz_d;
            vld_q   <= vld_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid     = vld_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_div_zero  = dz_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_div_sched.sv
// Directed bench for alu_div_sched: a vector table for single divisions, followed by
// hand-written arbitration, backpressure and mid-division reset sequences.
module tb_alu_div_sched;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*W-1:0] req_dividend, req_divisor;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_div_zero, busy;
    logic [W-1:0]  rsp_quotient, rsp_remainder;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_div_sched #(.WIDTH(W), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_zero(rsp_div_zero), .busy(busy)
    );

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Presents one request; lat counts edges from the acceptance edge (=1) to first rsp_valid.
    task automatic run_one(input logic id, input logic [7:0] a, input logic [7:0] b,
                           output int lat);
        req_dividend = id ? {a, 8'h00} : {8'h00, a};
        req_divisor  = id ? {b, 8'h00} : {8'h00, b};
        req_valid    = id ? 2'b10 : 2'b01;
        rsp_ready    = 1'b1;
        #1;
        chk("vec_grant", int'(req_ready), id ? 2 : 1);
        lat = 0;
        do begin
            tick;
            lat++;
            if (lat == 1) begin
                req_valid    = 2'b00;
                req_dividend = ~req_dividend;
                req_divisor  = ~req_divisor;
            end
        end while (!rsp_valid && lat < 30);
    endtask

    initial begin
        int lat, n, ng, cyc, last_g;
        logic [1:0] exp_gnt;

        vecs[0] = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
        vecs[1] = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        vecs[2] = '{1'b1, 8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        vecs[3] = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        vecs[4] = '{1'b1, 8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
        vecs[5] = '{1'b1, 8'd13,  8'd0,   8'hFF,  8'd13, 1'b1};
        vecs[6] = '{1'b0, 8'd0,   8'd0,   8'hFF,  8'd0,  1'b1};
        vecs[7] = '{1'b1, 8'd100, 8'd10,  8'd10,  8'd0,  1'b0};

        rst = 1'b0; req_valid = 2'b00; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b0;
        tick; tick;
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_q", int'(rsp_quotient), 0);
        chk("rst_r", int'(rsp_remainder), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_dz", int'(rsp_div_zero), 0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].id, vecs[i].a, vecs[i].b, lat);
            chk("vec_latency", lat, vecs[i].dz ? 1 : W + 1);
            chk("vec_q", int'(rsp_quotient), int'(vecs[i].q));
            chk("vec_r", int'(rsp_remainder), int'(vecs[i].r));
            chk("vec_dz", int'(rsp_div_zero), int'(vecs[i].dz));
            chk("vec_id", int'(rsp_id), int'(vecs[i].id));
            tick;
            chk("vec_consumed", int'(rsp_valid), 0);
        end

        // Arbitration: both requesters valid from reset, results consumed immediately.
        rst = 1'b0; tick; rst = 1'b1;
        req_dividend = {8'd50, 8'd100};
        req_divisor  = {8'd6, 8'd10};
        req_valid    = 2'b11;
        rsp_ready    = 1'b1;
        #1;
        ng = 0; cyc = 0; last_g = 0;
        while (ng < 4 && cyc < 100) begin
            chk("arb_onehot", int'(req_ready != 2'b11), 1);
            if (req_ready != 2'b00) begin
                chk("arb_order", int'(req_ready[1]), ng % 2);
                if (ng > 0) chk("arb_spacing", cyc - last_g, W + 2);
                last_g = cyc;
                ng++;
            end
            if (rsp_valid) begin
                chk("arb_q", int'(rsp_quotient), rsp_id ? 8 : 10);
                chk("arb_r", int'(rsp_remainder), rsp_id ? 2 : 0);
            end
            tick;
            cyc++;
        end
        chk("arb_grants", ng, 4);
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        chk("arb_drain", int'(busy), 0);

        // Backpressure: requester 0 alone, result held while rsp_ready is low.
        req_dividend = {8'd50, 8'd200};
        req_divisor  = {8'd6, 8'd7};
        req_valid    = 2'b01;
        rsp_ready    = 1'b0;
        tick;
        req_valid = 2'b00;
        n = 0;
        while (!rsp_valid && n < 30) begin tick; n++; end
        chk("bp_valid", int'(rsp_valid), 1);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_hold_q", int'(rsp_quotient), 28);
            chk("bp_hold_r", int'(rsp_remainder), 4);
            chk("bp_hold_id", int'(rsp_id), 0);
            chk("bp_busy", int'(busy), 1);
            chk("bp_no_grant", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_release_valid", int'(rsp_valid), 0);
        chk("bp_release_busy", int'(busy), 0);
        exp_gnt = 2'b10;
        chk("bp_next_grant", int'(req_ready), int'(exp_gnt));
        tick;
        chk("bp_next_busy", int'(busy), 1);
        chk("bp_next_id", int'(rsp_id), 1);
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 30) begin tick; n++; end
        chk("bp_drain", int'(busy), 0);

        // Reset on the 4th CALC edge, after requester 0 was granted last.
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        tick; tick; tick;
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b0;
        tick;
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(req_ready), 0);
        chk("midrst_q", int'(rsp_quotient), 0);
        chk("midrst_r", int'(rsp_remainder), 0);
        chk("midrst_dz", int'(rsp_div_zero), 0);
        chk("midrst_id", int'(rsp_id), 0);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("midrst_ptr", int'(req_ready), 1);
        n = 0;
        while (!rsp_valid && n < 30) begin tick; n++; end
        chk("midrst_first_id", int'(rsp_id), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_div_sched.md
Name: alu_div_sched

Overview:
- Sequential restoring divider that serves two requesters through a round-robin arbiter.
- It replaces the single-cycle combinational divide/modulo path in the ALU block. Each request runs one iteration per clock, so the long divide chain leaves the critical path.
- Requester 0 is the ALU DIV/MOD port front end. Requester 1 is reserved for a second bus master, for example a debug or DMA engine.
- Operands are captured at grant. The result is held until the requester consumes it.

Parameters:
- WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder.
- CW, 4, iteration-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester grant; at most one bit high.
- req_dividend  in  2*WIDTH  requester i dividend at bits [i*WIDTH +: WIDTH].
- req_divisor  in  2*WIDTH  requester i divisor, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_quotient  out  WIDTH  quotient.
- rsp_remainder  out  WIDTH  remainder.
- rsp_div_zero  out  1  divisor was zero.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0 at an edge), including mid-operation:
  - state=IDLE, rsp_valid=0, busy=0, req_ready=0.
  - rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div_zero=0.
  - Round-robin pointer is set so requester 0 has priority.
  - Any in-flight division is dropped; no response is produced for it.
- States: IDLE, CALC, DONE.
- IDLE, arbitration (combinational):
  - req_ready[i]=1 only for the single winning requester among the valid ones.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that was not granted last wins.
  - req_ready is 0 in CALC and DONE.
- Acceptance edge (req_valid[i] & req_ready[i]):
  - Capture dividend and divisor; rsp_id<=i; last-grant pointer<=i.
  - Divisor nonzero: clear the partial remainder, counter<=0, go to CALC.
  - Divisor zero: go directly to DONE with quotient=all ones, remainder=dividend, div_zero=1.
- CALC:
  - One restoring step per edge, MSB first: shift {rem, dividend-bit} left; if the shifted value >= divisor, subtract and set the quotient bit.
  - The compare/subtract is WIDTH+1 bits wide so there is no overflow.
  - After WIDTH edges (counter reaches WIDTH-1 on the last step), go to DONE.
  - rsp_valid is first high in the cycle after the WIDTH-th CALC edge, i.e. WIDTH+1 clocks after the acceptance edge.
- DONE:
  - rsp_valid=1; rsp_quotient, rsp_remainder, rsp_id and rsp_div_zero are stable while rsp_ready=0.
  - Edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - No new grant is given in the same cycle; the earliest next acceptance is the following edge. Minimum spacing between acceptances is therefore WIDTH+2 clocks for nonzero divisors.
- Changes to req_* inputs after acceptance have no effect on the running division.
- A requester that drops req_valid while in IDLE loses the grant with no side effect.
- rsp_div_zero is 0 for every nonzero divisor.

Test Plan:
- Single request, WIDTH=8: requester 0 sends 200/7 → accepted on the first edge; rsp_valid high 9 clocks later; q=28, r=4, rsp_id=0, div_zero=0.
- Boundary values: 255/1 → q=255, r=0. 5/9 → q=0, r=5. 255/255 → q=1, r=0. 0/3 → q=0, r=0.
- Divide by zero: requester 1 sends 13/0 → rsp_valid the cycle after acceptance; q=8'hFF, r=13, div_zero=1, rsp_id=1.
- Arbitration: after reset both requesters are valid continuously (0: 100/10, 1: 50/6), rsp_ready=1 → grants alternate 0,1,0,1; results (10,0) and (8,2) alternate; req_ready is never high for both bits.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → outputs stay constant, busy=1, req_ready=0 even with requests pending; raise rsp_ready → IDLE on the next edge, new grant on the edge after.
- Reset mid-CALC: assert rst=0 at the 4th CALC edge → next cycle all outputs are 0 and state is IDLE; with both requesters valid afterwards, requester 0 is granted first.
